// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared opcodes, FSM state type and word type for control_unit
package control_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic is_jump(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/control_unit_wait_timer.sv
// rtl/control_unit_wait_timer.sv - memory wait counter; expired flags the LIMIT-th stalled cycle
module wait_timer #(
    parameter int LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] cnt_q;

    // Expiry is seen during the stalled cycle itself, so the FSM leaves on that edge.
    assign expired = (LIMIT != 0) && enable && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle CPU control FSM; ILLEGAL_TRAP_EN traps unknown opcodes to HALT
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_valid,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       rf_we,
    output logic       retire,
    output logic       fault,
    output logic [2:0] state
);

    ctrl_state_t state_q, state_d;
    logic        fault_q, fault_d;
    logic        expired;
    logic        wait_en, wait_clr;

    assign wait_en  = mem_valid & ~mem_ready;
    assign wait_clr = mem_ready | (state_d != state_q);

    wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (wait_en),
        .clear   (wait_clr),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_valid = 1'b1;
                if (expired) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMORY;
                    OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: state_d = WRITEBACK;
                    OP_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        fault_d = 1'b1;
                        state_d = HALT;
`else
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
`endif
                    end
                endcase
            end
            MEMORY: begin
                mem_valid = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (opcode == OP_STORE);
                if (expired) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = is_jump(opcode);
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
        // A reset cycle must not commit anything, even if memory completes in it.
        if (reset) begin
            ir_we  = 1'b0;
            pc_we  = 1'b0;
            rf_we  = 1'b0;
            retire = 1'b0;
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with directed per-cycle vectors
module tb_control_unit;
    import control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_valid, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, retire, fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    control_unit #(.WAIT_LIMIT(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .retire       (retire),
        .fault        (fault),
        .state        (state)
    );

    // Expected word: {state, mem_valid, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, retire, fault}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [11:0] act, exp;
            string nm;
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {state, mem_valid, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, retire, fault};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %b required %b", nm, act, exp);
            end
        end
    end

    task automatic step(input string nm, input logic [6:0] op, input logic bt, input logic rdy,
                        input logic rst, input logic chk, input logic [2:0] st, input logic [8:0] o);
        @(posedge clk);
        #1;
        opcode       = op;
        branch_taken = bt;
        mem_ready    = rdy;
        reset        = rst;
        if (chk) begin
            exp_q.push_back({st, o});
            name_q.push_back(nm);
        end
    endtask

    initial begin
        step("reset",        OP_ALUI, 0, 0, 1, 0, 3'd0, 9'b000000000);
        // addi, ready always high: 4 cycles
        step("addi_fetch",   OP_ALUI, 0, 1, 0, 1, 3'd0, 9'b100100000);
        step("addi_decode",  OP_ALUI, 0, 1, 0, 1, 3'd1, 9'b000000000);
        step("addi_exec",    OP_ALUI, 0, 1, 0, 1, 3'd2, 9'b000000000);
        step("addi_wb",      OP_ALUI, 0, 1, 0, 1, 3'd4, 9'b000010110);
        // lw with 3 stalled memory cycles: 8 cycles
        step("lw_fetch",     OP_LOAD, 0, 1, 0, 1, 3'd0, 9'b100100000);
        step("lw_decode",    OP_LOAD, 0, 0, 0, 1, 3'd1, 9'b000000000);
        step("lw_exec",      OP_LOAD, 0, 0, 0, 1, 3'd2, 9'b000000000);
        for (int i = 0; i < 3; i++)
            step("lw_mem_wait", OP_LOAD, 0, 0, 0, 1, 3'd3, 9'b101000000);
        step("lw_mem_done",  OP_LOAD, 0, 1, 0, 1, 3'd3, 9'b101000000);
        step("lw_wb",        OP_LOAD, 0, 1, 0, 1, 3'd4, 9'b000010110);
        // beq taken / not taken: 3 cycles, no rf_we
        step("beqt_fetch",   OP_BRANCH, 1, 1, 0, 1, 3'd0, 9'b100100000);
        step("beqt_decode",  OP_BRANCH, 1, 1, 0, 1, 3'd1, 9'b000000000);
        step("beqt_exec",    OP_BRANCH, 1, 1, 0, 1, 3'd2, 9'b000011010);
        step("beqn_fetch",   OP_BRANCH, 0, 1, 0, 1, 3'd0, 9'b100100000);
        step("beqn_decode",  OP_BRANCH, 0, 1, 0, 1, 3'd1, 9'b000000000);
        step("beqn_exec",    OP_BRANCH, 0, 1, 0, 1, 3'd2, 9'b000010010);
        // sw: 4 cycles
        step("sw_fetch",     OP_STORE, 0, 1, 0, 1, 3'd0, 9'b100100000);
        step("sw_decode",    OP_STORE, 0, 1, 0, 1, 3'd1, 9'b000000000);
        step("sw_exec",      OP_STORE, 0, 1, 0, 1, 3'd2, 9'b000000000);
        step("sw_mem",       OP_STORE, 0, 1, 0, 1, 3'd3, 9'b111010010);
        // jal: writeback selects the ALU target
        step("jal_fetch",    OP_JAL, 0, 1, 0, 1, 3'd0, 9'b100100000);
        step("jal_decode",   OP_JAL, 0, 1, 0, 1, 3'd1, 9'b000000000);
        step("jal_exec",     OP_JAL, 0, 1, 0, 1, 3'd2, 9'b000000000);
        step("jal_wb",       OP_JAL, 0, 1, 0, 1, 3'd4, 9'b000011110);
        // reset in MEMORY together with mem_ready: nothing commits
        step("rst_fetch",    OP_LOAD, 0, 1, 0, 1, 3'd0, 9'b100100000);
        step("rst_decode",   OP_LOAD, 0, 1, 0, 1, 3'd1, 9'b000000000);
        step("rst_exec",     OP_LOAD, 0, 1, 0, 1, 3'd2, 9'b000000000);
        step("rst_in_mem",   OP_LOAD, 0, 1, 1, 1, 3'd3, 9'b101000000);
        step("post_rst",     OP_ALU,  0, 0, 0, 1, 3'd0, 9'b100000000);
        step("alu_fetch",    OP_ALU,  0, 1, 0, 1, 3'd0, 9'b100100000);
        step("alu_decode",   OP_ALU,  0, 1, 0, 1, 3'd1, 9'b000000000);
        step("alu_exec",     OP_ALU,  0, 1, 0, 1, 3'd2, 9'b000000000);
        step("alu_wb",       OP_ALU,  0, 1, 0, 1, 3'd4, 9'b000010110);
        // fetch timeout after 5 stalled cycles, HALT absorbing, reset recovers
        for (int i = 0; i < 5; i++)
            step("to_wait",  OP_ALU,  0, 0, 0, 1, 3'd0, 9'b100000000);
        step("to_halt",      OP_ALU,  0, 1, 0, 1, 3'd5, 9'b000000001);
        step("halt_hold",    OP_ALU,  0, 1, 0, 1, 3'd5, 9'b000000001);
        step("halt_rst",     OP_ALU,  0, 0, 1, 1, 3'd5, 9'b000000001);
        step("halt_recover", OP_ALU,  0, 0, 0, 1, 3'd0, 9'b100000000);
        // illegal opcode 0
        step("ill_fetch",    7'b0000000, 0, 1, 0, 1, 3'd0, 9'b100100000);
        step("ill_decode",   7'b0000000, 0, 1, 0, 1, 3'd1, 9'b000000000);
`ifdef ILLEGAL_TRAP_EN
        step("ill_exec",     7'b0000000, 0, 1, 0, 1, 3'd2, 9'b000000000);
        step("ill_after",    7'b0000000, 0, 0, 0, 1, 3'd5, 9'b000000001);
`else
        step("ill_exec",     7'b0000000, 0, 1, 0, 1, 3'd2, 9'b000010010);
        step("ill_after",    7'b0000000, 0, 0, 0, 1, 3'd0, 9'b100000000);
`endif
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 0, meaning the maximum number of cycles a memory request waits for mem_ready (0 = unlimited).
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  7  opcode field of the latched instruction register, taken from the instruction decoder.
REQ-005 SHALL have port branch_taken  input  1  branch comparison result, valid in EXECUTE.
REQ-006 SHALL have port mem_ready  input  1  memory accepts or completes the current request.
REQ-007 SHALL have port mem_valid  output  1  memory request active.
REQ-008 SHALL have port mem_we  output  1  request is a write.
REQ-009 SHALL have port addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 SHALL have port ir_we  output  1  load the instruction register.
REQ-011 SHALL have port pc_we  output  1  update the PC.
REQ-012 SHALL have port pc_sel  output  1  next-PC source: 0 = PC+4, 1 = ALU target.
REQ-013 SHALL have port rf_we  output  1  register-file write enable.
REQ-014 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-015 SHALL have port fault  output  1  sticky error flag (timeout or illegal opcode).
REQ-016 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-017 SHALL implement the states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and HALT.
REQ-018 FETCH SHALL assert mem_valid=1, mem_we=0 and addr_sel=0, holding them until mem_ready; in the mem_ready cycle it SHALL pulse ir_we and go to DECODE.
REQ-019 DECODE SHALL last exactly one cycle and then go to EXECUTE.
REQ-020 EXECUTE SHALL route OP_LOAD and OP_STORE to MEMORY.
REQ-021 EXECUTE SHALL route OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_JAL and OP_JALR to WRITEBACK.
REQ-022 For OP_BRANCH, EXECUTE SHALL assert pc_we, set pc_sel=branch_taken, pulse retire and go to FETCH.
REQ-023 MEMORY SHALL assert mem_valid=1 and addr_sel=1, with mem_we=1 only for OP_STORE.
REQ-024 On mem_ready in MEMORY, a store SHALL assert pc_we with pc_sel=0, pulse retire and go to FETCH; a load SHALL go to WRITEBACK.
REQ-025 WRITEBACK SHALL assert rf_we and pc_we, with pc_sel=1 for OP_JAL and OP_JALR and 0 otherwise; it SHALL pulse retire and go to FETCH.
REQ-026 All outputs other than state SHALL be combinational from the state and inputs, with no glitch-relevant registering.
REQ-027 Latency with mem_ready tied to 1 SHALL be: ALU-class 4 cycles, branch 3, store 4, load 5.
REQ-028 A wait counter SHALL count cycles with mem_valid=1 and mem_ready=0, and SHALL clear on every mem_ready and on every state change.
REQ-029 When WAIT_LIMIT is nonzero and the wait counter reaches WAIT_LIMIT, the FSM SHALL set fault and go to HALT.
REQ-030 HALT SHALL be absorbing: all enables 0 and mem_valid 0 until reset.
REQ-031 mem_valid, once asserted, SHALL NOT drop before mem_ready, except on reset or timeout.

Reset
REQ-032 Reset SHALL force state=FETCH, clear fault and clear the wait counter.
REQ-033 Reset SHALL take priority over all other events, including a reset asserted mid-request or in the same cycle as mem_ready.
REQ-034 In the first cycle after reset, mem_valid SHALL be 1 and all other enables SHALL be 0.

Configuration
REQ-035 With ILLEGAL_TRAP_EN defined, an opcode in EXECUTE outside the nine listed SHALL set fault and go to HALT.
REQ-036 Without ILLEGAL_TRAP_EN, such an opcode SHALL be treated as a NOP: pc_we with pc_sel=0, retire pulse, return to FETCH, and fault unaffected.

Structure
REQ-037 The opcode constants (OP_*), the ctrl_state_t enum and the word type SHALL live in the shared Types package.
REQ-038 The wait/timeout counter SHALL be a sub-module named wait_timer (inputs enable, clear; output expired).

Verification
REQ-039 addi with mem_ready always 1: FETCH→DECODE→EXECUTE→WRITEBACK, rf_we=1 and retire=1 in cycle 4, next fetch in cycle 5.
REQ-040 lw with mem_ready delayed 3 cycles in MEMORY: mem_valid stays 1 and mem_we 0 for 4 cycles, then WRITEBACK with rf_we=1; 8 cycles total.
REQ-041 beq with branch_taken=1: pc_we=1, pc_sel=1 and retire=1 in EXECUTE; no rf_we pulse across the instruction.
REQ-042 WAIT_LIMIT=5 with mem_ready held at 0 in FETCH: fault=1 and state=HALT after 5 wait cycles; reset returns to FETCH with fault=0.
REQ-043 opcode 7'b0000000: with ILLEGAL_TRAP_EN defined → HALT with fault=1; without it → retire pulse, PC+4, FETCH.
REQ-044 Reset asserted during MEMORY with mem_ready=1 in the same cycle: next state is FETCH, with no pc_we, rf_we or retire.
